// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction queue between fetch and decode/rename
// Optional same-cycle bypass into an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int XLEN       = 32,
  parameter int FetchWidth = 2,
  parameter int IssueWidth = 2,
  parameter int Depth      = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           push_valid_i,
  input  logic [$clog2(FetchWidth+1)-1:0] push_count_i,
  input  logic [FetchWidth*32-1:0]       push_instr_i,
  input  logic [XLEN-1:0]                push_pc_i,
  output logic                           push_ready_o,
  output logic [IssueWidth-1:0]          pop_valid_o,
  output logic [IssueWidth*32-1:0]       pop_instr_o,
  output logic [IssueWidth*XLEN-1:0]     pop_pc_o,
  input  logic                           pop_ready_i,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int AW  = $clog2(Depth);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(Depth + 1);
  localparam int FCW = $clog2(FetchWidth + 1);

  localparam logic [PW-1:0]  ISSUE_C = PW'(IssueWidth);
  localparam logic [PW-1:0]  ROOM_C  = PW'(Depth - FetchWidth);
  localparam logic [FCW-1:0] FETCH_C = FCW'(FetchWidth);

  logic [31:0]     instr_mem [Depth];
  logic [XLEN-1:0] pc_mem    [Depth];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head, tail, count, n_avail, n_eff, push_amt;
  logic          push_fire, pop_fire, bypass;

  assign count        = tail - head;
  assign count_o      = CW'(count);
  assign push_ready_o = (count <= ROOM_C);
  assign push_amt     = PW'(push_count_i);
  assign n_avail      = (count < ISSUE_C) ? count : ISSUE_C;
  assign push_fire    = push_valid_i && push_ready_o && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic [PW-1:0] byp_n;
  assign byp_n  = (push_amt < ISSUE_C) ? push_amt : ISSUE_C;
  assign bypass = push_fire && (count == '0);
  // Bypassed slots are still written; advancing head past them discards them.
  assign n_eff  = bypass ? byp_n : n_avail;
`else
  assign bypass = 1'b0;
  assign n_eff  = n_avail;
`endif

  assign pop_fire = pop_ready_i && (n_eff != '0) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push_fire) tail <= tail + push_amt;
      if (pop_fire)  head <= head + n_eff;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      for (int k = 0; k < FetchWidth; k++) begin
        if (FCW'(k) < push_count_i) begin
          instr_mem[AW'(tail + PW'(k))] <= push_instr_i[32*k +: 32];
          pc_mem[AW'(tail + PW'(k))]    <= push_pc_i + XLEN'(4 * k);
        end
      end
    end
  end

  for (genvar k = 0; k < IssueWidth; k++) begin : g_pop
    logic [AW-1:0] ridx;
    assign ridx           = AW'(head + PW'(k));
    assign pop_valid_o[k] = !flush_i && (PW'(k) < n_eff);
    if (k < FetchWidth) begin : g_byp
      assign pop_instr_o[32*k +: 32]     = bypass ? push_instr_i[32*k +: 32] : instr_mem[ridx];
      assign pop_pc_o[XLEN*k +: XLEN]    = bypass ? push_pc_i + XLEN'(4 * k) : pc_mem[ridx];
    end else begin : g_mem
      assign pop_instr_o[32*k +: 32]     = instr_mem[ridx];
      assign pop_pc_o[XLEN*k +: XLEN]    = pc_mem[ridx];
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && push_valid_i)
      assert (push_count_i <= FETCH_C)
      else $error("push_count_i %0d exceeds FetchWidth", push_count_i);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic [1:0]  push_count;
  logic [63:0] push_instr;
  logic [31:0] push_pc;
  logic        push_ready;
  logic [1:0]  pop_valid;
  logic [63:0] pop_instr;
  logic [63:0] pop_pc;
  logic        pop_ready;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  fetch_queue dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_count_i (push_count),
    .push_instr_i (push_instr),
    .push_pc_i    (push_pc),
    .push_ready_o (push_ready),
    .pop_valid_o  (pop_valid),
    .pop_instr_o  (pop_instr),
    .pop_pc_o     (pop_pc),
    .pop_ready_i  (pop_ready),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] n, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc, input logic pr,
                       input logic fl);
    push_valid = pv;
    push_count = n;
    push_instr = {i1, i0};
    push_pc    = pc;
    pop_ready  = pr;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v, input logic [3:0] c,
                         input logic [31:0] i0, input logic [31:0] pc0,
                         input logic [31:0] i1, input logic [31:0] pc1);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".valid"}, 32'(pop_valid), 32'(v));
    if (v[0]) begin
      chk({tag, ".instr0"}, pop_instr[31:0], i0);
      chk({tag, ".pc0"}, pop_pc[31:0], pc0);
    end
    if (v[1]) begin
      chk({tag, ".instr1"}, pop_instr[63:32], i1);
      chk({tag, ".pc1"}, pop_pc[63:32], pc1);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.valid", 32'(pop_valid), 32'd0);
    chk("reset.ready", 32'(push_ready), 32'd1);
    rst = 1'b0;

    // Basic push, one-cycle latency, then pop
    drive(1'b1, 2'd2, 32'h00000013, 32'h00100093, 32'h1000, 1'b0, 1'b0);
    tick();
    idle();
    chk_out("basic", 2'b11, 4'd2, 32'h00000013, 32'h1000, 32'h00100093, 32'h1004);
    pop_ready = 1'b1;
    tick();
    idle();
    chk_out("basic_pop", 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // push_count = 0 is a no-op
    drive(1'b1, 2'd0, 32'hdead, 32'hbeef, 32'h9000, 1'b0, 1'b0);
    tick();
    idle();
    chk("zero_push.count", 32'(count), 32'd0);

    // Fill to 8 without popping; fifth push is ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd2, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 32'h2000 + 32'(8*i), 1'b0, 1'b0);
      tick();
      if (i == 3) begin
        chk("fill4.count", 32'(count), 32'd8);
        chk("fill4.ready", 32'(push_ready), 32'd0);
      end
    end
    idle();
    chk_out("fill5", 2'b11, 4'd8, 32'h100, 32'h2000, 32'h101, 32'h2004);

    // Full: pop with a refused push, then push accepted alongside pop
    drive(1'b1, 2'd2, 32'hbad0, 32'hbad1, 32'h2020, 1'b1, 1'b0);
    tick();
    chk_out("full_pop", 2'b11, 4'd6, 32'h102, 32'h2008, 32'h103, 32'h200c);
    chk("full_pop.ready", 32'(push_ready), 32'd1);
    drive(1'b1, 2'd2, 32'h200, 32'h201, 32'h3000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_out("pushpop", 2'b11, 4'd6, 32'h104, 32'h2010, 32'h105, 32'h2014);
    tick();
    chk_out("drain1", 2'b11, 4'd4, 32'h106, 32'h2018, 32'h107, 32'h201c);
    tick();
    chk_out("drain2", 2'b11, 4'd2, 32'h200, 32'h3000, 32'h201, 32'h3004);
    tick();
    idle();
    chk_out("drain3", 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Fill to 7 with a push straddling index 7 -> 0, then drain
    drive(1'b1, 2'd1, 32'h300, 32'h0, 32'h4000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, 32'h301 + 32'(2*i), 32'h302 + 32'(2*i), 32'h4004 + 32'(8*i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_out("wrap_fill", 2'b11, 4'd7, 32'h300, 32'h4000, 32'h301, 32'h4004);
    tick();
    chk_out("wrap_d1", 2'b11, 4'd5, 32'h302, 32'h4008, 32'h303, 32'h400c);
    tick();
    chk_out("wrap_d2", 2'b11, 4'd3, 32'h304, 32'h4010, 32'h305, 32'h4014);
    tick();
    chk_out("wrap_d3", 2'b01, 4'd1, 32'h306, 32'h4018, 32'h0, 32'h0);
    tick();
    idle();
    chk_out("wrap_d4", 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 2'd2, 32'h400, 32'h401, 32'h5000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 32'h402, 32'h403, 32'h5008, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_out("refill", 2'b11, 4'd2, 32'h402, 32'h5008, 32'h403, 32'h500c);
    tick();
    idle();

    // Flush with count 5 and concurrent push/pop
    drive(1'b1, 2'd2, 32'h500, 32'h501, 32'h6000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 32'h502, 32'h503, 32'h6008, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 32'h504, 32'h0, 32'h6010, 1'b0, 1'b0);
    tick();
    chk("preflush.count", 32'(count), 32'd5);
    drive(1'b1, 2'd2, 32'h600, 32'h601, 32'h6100, 1'b1, 1'b1);
    #1;
    chk("flush.valid", 32'(pop_valid), 32'd0);
    tick();
    idle();
    chk_out("postflush", 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("postflush.ready", 32'(push_ready), 32'd1);
    drive(1'b1, 2'd2, 32'h700, 32'h701, 32'h7000, 1'b0, 1'b0);
    tick();
    idle();
    chk_out("flush_accept", 2'b11, 4'd2, 32'h700, 32'h7000, 32'h701, 32'h7004);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.valid", 32'(pop_valid), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 2'd1, 32'h800, 32'h0, 32'h8000, 1'b0, 1'b0);
    tick();
    idle();
    chk_out("after_rst", 2'b01, 4'd1, 32'h800, 32'h8000, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
